// File: rtl/jenc_pkg.sv
// rtl/jenc_pkg.sv - shared state type, EOI marker constants and byte-enable helpers for the JPEG buffer controller
package jenc_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_EOI, ST_DONE} state_e;

  localparam logic [15:0] EOI_MARKER     = 16'hFFD9;
  localparam int          BYTES_PER_WORD = 16;

  // MSB-first mask: n valid bytes starting at byte0 (bit15)
  function automatic logic [15:0] bytes_to_be(input logic [4:0] n);
    logic [15:0] be;
    if (n >= 5'd16) be = 16'hFFFF;
    else            be = ~(16'hFFFF >> n);
    return be;
  endfunction

  function automatic logic [127:0] be_to_mask(input logic [15:0] be);
    logic [127:0] m;
    for (int i = 0; i < 16; i++) m[8*i +: 8] = {8{be[i]}};
    return m;
  endfunction

endpackage

// File: rtl/jenc_eoi_merge.sv
// rtl/jenc_eoi_merge.sv - splices the FFD9 marker behind the last beat, spilling into a second word when needed
module jenc_eoi_merge
  import jenc_pkg::*;
(
  input  logic [127:0] last_data_i,
  input  logic [4:0]   last_n_i,
  output logic [127:0] first_data_o,
  output logic [15:0]  first_be_o,
  output logic [127:0] second_data_o,
  output logic [15:0]  second_be_o,
  output logic         needs_second_o
);

  logic [7:0]   shift_bits;
  logic [127:0] marker_word;

  always_comb begin
    shift_bits     = {last_n_i, 3'b000};
    marker_word    = {EOI_MARKER, 112'd0} >> shift_bits;
    first_data_o   = (last_data_i & be_to_mask(bytes_to_be(last_n_i))) | marker_word;
    needs_second_o = (int'(last_n_i) + 2) > BYTES_PER_WORD;
    first_be_o     = needs_second_o ? 16'hFFFF : bytes_to_be(last_n_i + 5'd2);
    // n==15 leaves only D9 for the next word; n==16 pushes the whole marker over
    if (int'(last_n_i) == BYTES_PER_WORD - 1) begin
      second_data_o = {EOI_MARKER[7:0], 120'd0};
      second_be_o   = 16'h8000;
    end else begin
      second_data_o = {EOI_MARKER, 112'd0};
      second_be_o   = 16'hC000;
    end
  end

endmodule

// File: rtl/jenc_buffer_ctrl.sv
// rtl/jenc_buffer_ctrl.sv - frame sequencer owning the image buffer write port; EOI append enabled by JENC_EOI_APPEND_EN
module jenc_buffer_ctrl
  import jenc_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int BASE_ADDR = 0,
  parameter int LEN_W     = 20
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [127:0]      in_data_i,
  input  logic [4:0]        in_bytes_i,
  input  logic              in_tlast_i,
  input  logic              in_valid_i,
  output logic              in_hold_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [127:0]      wr_data_o,
  output logic [15:0]       wr_be_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              overflow_o,
  output logic [LEN_W-1:0]  frame_bytes_o
);

  localparam logic [ADDR_W:0] BASE_PTR = (ADDR_W+1)'(BASE_ADDR);

  state_e              state_q;
  logic [ADDR_W:0]     ptr_q;  // next write address; MSB set means the buffer is exhausted
  logic [LEN_W-1:0]    cnt_q;
  logic                wr_en_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [127:0]        wr_data_q;
  logic [15:0]         wr_be_q;
  logic                done_q;
  logic                ovf_q;
  logic [LEN_W-1:0]    frame_bytes_q;

  logic                accept;
  logic                wr_req_d;
  logic [127:0]        wr_data_d;
  logic [15:0]         wr_be_d;
  logic                frame_end_d;
  logic [4:0]          cnt_inc_d;
  logic [LEN_W-1:0]    cnt_d;

`ifdef JENC_EOI_APPEND_EN
  logic [127:0] last_data_q;
  logic [4:0]   last_n_q;
  logic         eoi_second_q;
  logic [127:0] eoi_first_data, eoi_second_data;
  logic [15:0]  eoi_first_be, eoi_second_be;
  logic         eoi_needs_second;

  jenc_eoi_merge u_eoi_merge (
    .last_data_i    (last_data_q),
    .last_n_i       (last_n_q),
    .first_data_o   (eoi_first_data),
    .first_be_o     (eoi_first_be),
    .second_data_o  (eoi_second_data),
    .second_be_o    (eoi_second_be),
    .needs_second_o (eoi_needs_second)
  );
`endif

  function automatic logic [LEN_W-1:0] sat_add(input logic [LEN_W-1:0] a, input logic [4:0] b);
    logic [LEN_W:0] s;
    s = {1'b0, a} + {{(LEN_W-4){1'b0}}, b};
    return s[LEN_W] ? '1 : s[LEN_W-1:0];
  endfunction

  assign accept = in_valid_i && (state_q == ST_RUN);

  always_comb begin
    wr_req_d    = 1'b0;
    wr_data_d   = in_data_i;
    wr_be_d     = bytes_to_be(in_bytes_i);
    frame_end_d = 1'b0;
    cnt_inc_d   = accept ? in_bytes_i : 5'd0;
    case (state_q)
      ST_RUN: begin
`ifdef JENC_EOI_APPEND_EN
        wr_req_d = accept && !in_tlast_i;
`else
        wr_req_d    = accept;
        frame_end_d = accept && in_tlast_i;
`endif
      end
`ifdef JENC_EOI_APPEND_EN
      ST_EOI: begin
        wr_req_d = 1'b1;
        if (eoi_second_q) begin
          wr_data_d   = eoi_second_data;
          wr_be_d     = eoi_second_be;
          frame_end_d = 1'b1;
        end else begin
          wr_data_d   = eoi_first_data;
          wr_be_d     = eoi_first_be;
          frame_end_d = !eoi_needs_second;
        end
        if (frame_end_d) cnt_inc_d = 5'd2;
      end
`endif
      default: ;
    endcase
    cnt_d = sat_add(cnt_q, cnt_inc_d);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= ST_IDLE;
      ptr_q         <= BASE_PTR;
      cnt_q         <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= BASE_PTR[ADDR_W-1:0];
      wr_data_q     <= '0;
      wr_be_q       <= '0;
      done_q        <= 1'b0;
      ovf_q         <= 1'b0;
      frame_bytes_q <= '0;
`ifdef JENC_EOI_APPEND_EN
      last_data_q   <= '0;
      last_n_q      <= '0;
      eoi_second_q  <= 1'b0;
`endif
    end else if (abort_i) begin
      state_q <= ST_IDLE;
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      cnt_q   <= cnt_d;
      if (wr_req_d) begin
        if (!ptr_q[ADDR_W]) begin
          wr_en_q   <= 1'b1;
          wr_addr_q <= ptr_q[ADDR_W-1:0];
          wr_data_q <= wr_data_d;
          wr_be_q   <= wr_be_d;
          ptr_q     <= ptr_q + 1'b1;
        end else begin
          ovf_q <= 1'b1;
        end
      end
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            state_q   <= ST_RUN;
            ptr_q     <= BASE_PTR;
            wr_addr_q <= BASE_PTR[ADDR_W-1:0];
            cnt_q     <= '0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
          end
        end
`ifdef JENC_EOI_APPEND_EN
        ST_RUN: begin
          if (accept && in_tlast_i) begin
            state_q      <= ST_EOI;
            last_data_q  <= in_data_i;
            last_n_q     <= in_bytes_i;
            eoi_second_q <= 1'b0;
          end
        end
        ST_EOI: begin
          if (!frame_end_d) eoi_second_q <= 1'b1;
        end
`endif
        default: ;
      endcase
      if (frame_end_d) begin
        state_q       <= ST_DONE;
        done_q        <= 1'b1;
        frame_bytes_q <= cnt_d;
      end
    end
  end

  assign in_hold_o     = (state_q != ST_RUN);
  assign busy_o        = (state_q == ST_RUN) || (state_q == ST_EOI);
  assign wr_en_o       = wr_en_q;
  assign wr_addr_o     = wr_addr_q;
  assign wr_data_o     = wr_data_q;
  assign wr_be_o       = wr_be_q;
  assign done_o        = done_q;
  assign overflow_o    = ovf_q;
  assign frame_bytes_o = frame_bytes_q;

endmodule

// File: tb/tb_jenc_buffer_ctrl.sv
// tb/tb_jenc_buffer_ctrl.sv - directed and randomized frames checked against a byte-stream model of the buffer writes
module tb_jenc_buffer_ctrl;

  localparam int ADDR_W    = 2;
  localparam int BASE_ADDR = 0;
  localparam int LEN_W     = 7;
  localparam int DEPTH     = 1 << ADDR_W;
  localparam int LEN_MAX   = (1 << LEN_W) - 1;

  logic              clk = 1'b0;
  logic              reset, start, abort;
  logic [127:0]      in_data;
  logic [4:0]        in_bytes;
  logic              in_tlast, in_valid;
  logic              in_hold, wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [127:0]      wr_data;
  logic [15:0]       wr_be;
  logic              busy, done, overflow;
  logic [LEN_W-1:0]  frame_bytes;

  int tests = 0;
  int fails = 0;
  int cycle = 0;

  typedef struct {
    int           addr;
    logic [127:0] data;
    logic [15:0]  be;
    int           cyc;
  } wr_t;

  wr_t got_q[$];

  jenc_buffer_ctrl #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR), .LEN_W(LEN_W)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .abort_i(abort),
    .in_data_i(in_data), .in_bytes_i(in_bytes), .in_tlast_i(in_tlast), .in_valid_i(in_valid),
    .in_hold_o(in_hold), .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data), .wr_be_o(wr_be),
    .busy_o(busy), .done_o(done), .overflow_o(overflow), .frame_bytes_o(frame_bytes)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  always @(posedge clk) begin
    #1;
    if (wr_en === 1'b1) got_q.push_back('{int'(wr_addr), wr_data, wr_be, cycle});
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic wr_t pack(input logic [7:0] bq[$], input int addr);
    wr_t w;
    w.addr = addr; w.data = '0; w.be = '0; w.cyc = 0;
    foreach (bq[i]) begin
      w.data[127-8*i -: 8] = bq[i];
      w.be[15-i] = 1'b1;
    end
    return w;
  endfunction

  function automatic logic [127:0] keep(input logic [127:0] d, input logic [15:0] be);
    logic [127:0] r = '0;
    for (int i = 0; i < 16; i++) if (be[15-i]) r[127-8*i -: 8] = d[127-8*i -: 8];
    return r;
  endfunction

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Frame of nfull leading beats plus one tlast beat of last_n bytes.
  task automatic run_frame(input string tag, input int nfull, input int last_n,
                           input bit mid_rand, input bit gaps, input bit poke_start);
    int nb[$]; logic [127:0] bd[$]; logic [7:0] wb[$]; logic [7:0] lw[$];
    wr_t exp_q[$]; logic [127:0] t;
    int total = 0, k = 0, lastwords = 0, guard;
    bit exp_ovf;
    for (int b = 0; b < nfull; b++) nb.push_back(mid_rand ? int'($urandom_range(1, 16)) : 16);
    nb.push_back(last_n);
    foreach (nb[b]) begin
      bd.push_back({$urandom, $urandom, $urandom, $urandom});
      total += nb[b];
    end
    for (int b = 0; b < nb.size() - 1; b++) begin
      wb.delete(); t = bd[b];
      for (int i = 0; i < nb[b]; i++) wb.push_back(t[127-8*i -: 8]);
      exp_q.push_back(pack(wb, BASE_ADDR + k)); k++;
    end
    wb.delete(); t = bd[nb.size()-1];
    for (int i = 0; i < last_n; i++) wb.push_back(t[127-8*i -: 8]);
`ifdef JENC_EOI_APPEND_EN
    wb.push_back(8'hFF); wb.push_back(8'hD9); total += 2;
`endif
    while (wb.size() > 0) begin
      lw.delete();
      for (int i = 0; i < 16 && wb.size() > 0; i++) lw.push_back(wb.pop_front());
      exp_q.push_back(pack(lw, BASE_ADDR + k)); k++; lastwords++;
    end
    exp_ovf = (BASE_ADDR + k) > DEPTH;
    while (exp_q.size() > 0 && exp_q[exp_q.size()-1].addr >= DEPTH) void'(exp_q.pop_back());
    if (total > LEN_MAX) total = LEN_MAX;

    got_q.delete();
    pulse_start();
    check({tag, "_busy_after_start"}, busy, 1);
    check({tag, "_done_cleared"}, done, 0);
    check({tag, "_ovf_cleared"}, overflow, 0);
    for (int b = 0; b < nb.size(); b++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0; in_data = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
      end
      in_valid = 1'b1; in_data = bd[b]; in_bytes = 5'(nb[b]); in_tlast = (b == nb.size() - 1);
      if (poke_start && b == 1) start = 1'b1;
      guard = 0;
      while (in_hold && guard < 20) begin @(negedge clk); guard++; end
      @(negedge clk); start = 1'b0;
    end
    in_valid = 1'b0; in_tlast = 1'b0;
    guard = 0;
    while (!done && guard < 10) begin @(negedge clk); guard++; end
    check({tag, "_done"}, done, 1);
    check({tag, "_busy_idle"}, busy, 0);
    check({tag, "_hold_idle"}, in_hold, 1);
    check({tag, "_overflow"}, overflow, exp_ovf);
    check({tag, "_frame_bytes"}, frame_bytes, total);
    check({tag, "_num_writes"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check($sformatf("%s_w%0d_addr", tag, i), got_q[i].addr, exp_q[i].addr);
      check($sformatf("%s_w%0d_be", tag, i), got_q[i].be, exp_q[i].be);
      check($sformatf("%s_w%0d_data", tag, i), keep(got_q[i].data, exp_q[i].be), exp_q[i].data);
    end
    if (!exp_ovf && lastwords == 2 && got_q.size() >= 2)
      check({tag, "_eoi_back_to_back"}, got_q[got_q.size()-1].cyc - got_q[got_q.size()-2].cyc, 1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    in_data = '0; in_bytes = 5'd16; in_tlast = 1'b0; in_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_hold", in_hold, 1);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, BASE_ADDR);
    check("rst_wr_data", wr_data, 0);
    check("rst_wr_be", wr_be, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_overflow", overflow, 0);
    check("rst_frame_bytes", frame_bytes, 0);

    run_frame("t1_3x16_5", 3, 5, 1'b0, 1'b0, 1'b1);
    run_frame("t2_last15", 1, 15, 1'b0, 1'b0, 1'b0);
    run_frame("t3_last16", 1, 16, 1'b0, 1'b1, 1'b0);

    got_q.delete();
    in_valid = 1'b1; in_data = {$urandom, $urandom, $urandom, $urandom}; in_bytes = 5'd16;
    repeat (3) @(negedge clk);
    check("t4_hold_before_start", in_hold, 1);
    check("t4_no_write_before_start", got_q.size(), 0);
    in_valid = 1'b0;
    run_frame("t4_after_start", 0, 9, 1'b0, 1'b0, 1'b0);

    run_frame("t5_overflow", 6, 3, 1'b0, 1'b0, 1'b0);

    pulse_start();
    in_valid = 1'b1; in_bytes = 5'd16; in_tlast = 1'b0;
    for (int b = 0; b < 2; b++) begin
      in_data = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
    end
    in_valid = 1'b0; abort = 1'b1; start = 1'b1;
    got_q.delete();
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    check("t6_busy", busy, 0);
    check("t6_hold", in_hold, 1);
    check("t6_done", done, 0);
    in_valid = 1'b1;
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    check("t6_no_writes_after_abort", got_q.size(), 0);
    run_frame("t6_rearm", 2, 7, 1'b0, 1'b0, 1'b0);

    for (int f = 0; f < 30; f++)
      run_frame($sformatf("rnd%0d", f), int'($urandom_range(0, 7)), int'($urandom_range(1, 16)),
                1'b1, 1'b1, $urandom_range(0, 3) == 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
